// File: rtl/ct_spsram_pkg.sv
// ct_spsram shared types: clear-FSM state encoding, parity helper
// and read-latency limits for the parametrised single-port SRAM.
package ct_spsram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Widest write group the parity helper accepts; callers zero-extend.
    localparam int PAR_MAX_W = 256;

    function automatic logic even_parity(
        input logic [PAR_MAX_W-1:0] bits
    );
        return ^bits;
    endfunction

endpackage

// File: rtl/ct_spsram_init_ctrl.sv
// ct_spsram clear sequencer: INIT/READY FSM sweeping the array
// one word per cycle after reset or on an init request.
module ct_spsram_init_ctrl
    import ct_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_req,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we,
    output logic                  busy
);

    init_state_t           state;
    init_state_t           state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        unique case (state)
            ST_INIT: begin
                clr_we = 1'b1;
                if (cnt == '1) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_READY: begin
                if (init_req) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign clr_addr = cnt;
    assign busy     = (state == ST_INIT);

endmodule

// File: rtl/ct_spsram_param.sv
// ct_spsram_param: parametrised single-port SRAM with masked writes,
// 1/2-cycle read latency and a clear sequencer. Parity: CT_SPSRAM_PARITY_EN.
module ct_spsram_param
    import ct_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 59,
    parameter int WE_WIDTH   = 59,
    parameter int RD_LAT     = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  INIT_REQ,
    input  logic                  ERR_INJ,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_BUSY,
    output logic                  PERR
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int GRP   = DATA_WIDTH / WE_WIDTH;

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("ct_spsram_param: RD_LAT must be 1 or 2");
    end
    if (DATA_WIDTH % WE_WIDTH != 0) begin : g_bad_grp
        $error("ct_spsram_param: DATA_WIDTH not a multiple of WE_WIDTH");
    end
    if (GRP > PAR_MAX_W) begin : g_bad_par_w
        $error("ct_spsram_param: write group wider than PAR_MAX_W");
    end

    logic                  clr_we;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ct_spsram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_ctrl (
        .clk      (CLK),
        .rst      (RST),
        .init_req (INIT_REQ),
        .clr_addr (clr_addr),
        .clr_we   (clr_we),
        .busy     (busy)
    );

    logic ready;
    logic wr_en;
    logic rd_en;
    logic clr_en;

    assign ready  = !busy && !RST;
    assign wr_en  = ready && !CEN && !GWEN;
    assign rd_en  = ready && !CEN && GWEN;
    assign clr_en = clr_we && !RST;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] bit_mask;
    logic [DATA_WIDTH-1:0] merged;

    for (genvar g = 0; g < WE_WIDTH; g++) begin : g_mask
        assign bit_mask[g*GRP +: GRP] = {GRP{~WEN[g]}};
    end

    assign rd_word = mem[A];
    assign merged  = (rd_word & ~bit_mask) | (D & bit_mask);

    always_ff @(posedge CLK) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[A] <= merged;
        end
    end

    logic perr_rd;

`ifdef CT_SPSRAM_PARITY_EN
    logic [WE_WIDTH-1:0] pmem [DEPTH];
    logic [WE_WIDTH-1:0] wr_par;
    logic [WE_WIDTH-1:0] rd_par;
    logic [WE_WIDTH-1:0] par_merged;

    for (genvar g = 0; g < WE_WIDTH; g++) begin : g_par
        assign wr_par[g] = even_parity(PAR_MAX_W'(D[g*GRP +: GRP]));
        assign rd_par[g] = even_parity(PAR_MAX_W'(rd_word[g*GRP +: GRP]));
    end

    // Injected errors flip the stored bit, never the data itself.
    assign par_merged = (pmem[A] & WEN)
                      | ((wr_par ^ {WE_WIDTH{ERR_INJ}}) & ~WEN);

    always_ff @(posedge CLK) begin
        if (clr_en) begin
            pmem[clr_addr] <= '0;
        end else if (wr_en) begin
            pmem[A] <= par_merged;
        end
    end

    assign perr_rd = |(rd_par ^ pmem[A]);
`else
    logic unused_err_inj;
    assign unused_err_inj = ERR_INJ;
    assign perr_rd        = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] q1;
    logic                  p1;
    logic                  rd1_v;

    always_ff @(posedge CLK) begin
        if (RST) begin
            q1    <= '0;
            p1    <= 1'b0;
            rd1_v <= 1'b0;
        end else begin
            rd1_v <= rd_en;
            if (rd_en) begin
                q1 <= rd_word;
                p1 <= perr_rd;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] q2;
        logic                  p2;

        // Advance only behind a real read so idle cycles keep holding.
        always_ff @(posedge CLK) begin
            if (RST) begin
                q2 <= '0;
                p2 <= 1'b0;
            end else if (rd1_v) begin
                q2 <= q1;
                p2 <= p1;
            end
        end

        assign Q    = q2;
        assign PERR = p2;
    end else begin : g_lat1
        logic unused_rd1_v;
        assign unused_rd1_v = rd1_v;
        assign Q            = q1;
        assign PERR         = p1;
    end

    assign INIT_BUSY = busy;

endmodule
